multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control FSM for the LEGv8 core. It sits on the issuing side of the ALUop interface: it decodes the 11-bit instruction opcode, sequences fetch/decode/execute/memory/writeback, and drives `ALUop` plus every datapath strobe. The existing ALU control decoder turns `ALUop` and the opcode into the ALU `opt`. Memory accesses use a ready handshake, so the FSM stalls on wait states.

## Interface
- No parameters.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 11: instruction bits [31:21], taken from the IR.
- `zero` input 1: ALU zero flag, used for CBZ.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `ALUop` output 2: 00 add, 01 pass-B (CBZ test), 10 R-type by opcode.
- `ALUSrcA` output 1: 0 PC, 1 register A.
- `ALUSrcB` output 2: 00 register B, 01 constant 4, 10 sign-extended D-immediate, 11 sign-extended branch offset <<2.
- `IorD` output 1: 0 PC addresses memory, 1 ALUOut addresses memory.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `PCWrite`, `PCWriteCond` output 1 each: strobes.
- `MemtoReg` output 1: 1 selects MDR for writeback.
- `Reg2Loc` output 1: 1 selects Rt as the second read register (STUR, CBZ).
- `PCSource` output 1: 0 ALU result, 1 ALUOut.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `illegal` output 1: one-cycle pulse on an unrecognised opcode.

## Operation
- Opcode classes, decoded in DECODE:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR: 11111000010.
  - STUR: 11111000000.
  - CBZ: opcode[10:3]=10110100.
  - B: opcode[10:5]=000101.
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_RD, LD_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP.
- RESET: all outputs 0; next state is FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0.
  - While mem_ready=0: hold; IRWrite and PCWrite stay 0.
  - On mem_ready=1: IRWrite=1 and PCWrite=1; go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00, which computes the branch target into ALUOut. Reg2Loc=1 for STUR and CBZ. Next state:
  - LDUR or STUR: MEM_ADDR.
  - R-type: R_EXEC.
  - CBZ: BRANCH.
  - B: JUMP.
  - Anything else: FETCH with illegal=1.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state is MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: MemRead=1, IorD=1. Hold until mem_ready=1, then go to LD_WB.
- LD_WB: RegWrite=1, MemtoReg=1, retire=1; go to FETCH.
- MEM_WR: MemWrite=1, IorD=1, Reg2Loc=1. Hold until mem_ready=1; on that cycle retire=1 and go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10; go to R_WB.
- R_WB: RegWrite=1, MemtoReg=0, retire=1; go to FETCH.
- BRANCH: Reg2Loc=1, ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1, retire=1; go to FETCH. The datapath writes PC only if zero=1.
- JUMP: PCWrite=1, PCSource=1, retire=1; go to FETCH.
- Any output not listed for a state is 0 in that state.
- Outputs are decoded from the state register, plus opcode in DECODE/MEM_ADDR and mem_ready in the wait states.

## Timing
- Reset (async, active-low): state goes to RESET immediately and all outputs are 0. The first FETCH begins on the cycle after rst_n is released.
- Reset asserted mid-instruction (e.g. during MEM_WR): the write strobe drops immediately and no retire pulse is produced.
- Cycle counts with zero wait states:
  - R-type: 4.
  - LDUR: 5.
  - STUR: 4.
  - CBZ: 3.
  - B: 3.
- Each cycle that mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in all other states.
- IRWrite, PCWrite (in FETCH) and MemWrite completion occur only on the mem_ready=1 edge.
- `retire` and `illegal` are never high together; each is at most one pulse per instruction.
- The illegal path costs 2 cycles (FETCH, DECODE) and leaves register and memory state unchanged.

## Structure
- Shared package `legv8_ctrl_pkg` holds:
  - the state enum (4-bit);
  - the opcode constants for ADD/SUB/AND/ORR/LDUR/STUR, and the CBZ/B prefixes;
  - the ALUop encodings (`ALUOP_ADD`=00, `ALUOP_PASS`=01, `ALUOP_RTYPE`=10);
  - the ALUSrcB encodings.
- The existing ALU control decoder should import the same ALUop constants.
- Sub-module `legv8_opcode_class`: combinational, opcode to a one-hot class {rtype, ldur, stur, cbz, b, illegal}. It is reused by the FSM and the bench.

## Test plan
- Reset, then ADD opcode with mem_ready=1: outputs are 0 in the RESET cycle. Retire comes 4 cycles after FETCH starts, with ALUop=10 in R_EXEC and RegWrite=1 in R_WB.
- LDUR with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_RD: IRWrite pulses once, only on the ready cycle. Retire arrives after 8 cycles. MemtoReg=1 and RegWrite=1 in LD_WB.
- STUR 11111000000: MemWrite=1 and IorD=1 are held through wait states. Retire coincides with mem_ready=1, and RegWrite stays 0 throughout.
- CBZ 10110100xxx with zero=1, then with zero=0: BRANCH asserts ALUop=01, PCWriteCond=1 and PCSource=1 in both cases. Both take 3 cycles.
- B 000101xxxxx: JUMP asserts PCWrite=1 and PCSource=1, taking 3 cycles. Opcode 00000000000 gives illegal=1 in DECODE, followed by FETCH, with no retire.
- rst_n pulled low during MEM_WR: MemWrite drops in the same cycle. After release, RESET is followed by FETCH, and no retire pulse is produced for the aborted store.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control path: FSM states,
// opcode constants, ALUop and ALUSrcB encodings, and the opcode class bundle.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_LD_WB    = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_DIMM = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef struct packed {
    logic rtype;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier: maps the 11-bit opcode to a one-hot
// instruction class, with anything unrecognised flagged illegal.
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_t   class_o
);

  always_comb begin
    class_o = '0;
    if (is_rtype(opcode_i))
      class_o.rtype = 1'b1;
    else if (opcode_i == OP_LDUR)
      class_o.ldur = 1'b1;
    else if (opcode_i == OP_STUR)
      class_o.stur = 1'b1;
    else if (opcode_i[10:3] == OP_CBZ_PFX)
      class_o.cbz = 1'b1;
    else if (opcode_i[10:5] == OP_B_PFX)
      class_o.b = 1'b1;
    else
      class_o.illegal = 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the LEGv8 core: sequences each instruction
// and drives ALUop plus all datapath strobes, stalling on memory wait states.
module multicycle_control
  import legv8_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  ALUop,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        PCSource,
  output logic        retire,
  output logic        illegal
);

  state_e    state_q, state_d;
  op_class_t opClass;

  // The branch decision on zero is made in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  legv8_opcode_class u_class (
    .opcode_i (opcode),
    .class_o  (opClass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_RESET;
    else
      state_q <= state_d;
  end

  // Outputs decode straight from the state register so a reset drops every
  // strobe at once, while mem_ready gates the completion strobes in-cycle.
  always_comb begin
    state_d     = state_q;
    ALUop       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemtoReg    = 1'b0;
    Reg2Loc     = 1'b0;
    PCSource    = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ALUSrcB = SRCB_BOFF;
        Reg2Loc = opClass.stur | opClass.cbz;
        if (opClass.ldur || opClass.stur)
          state_d = ST_MEM_ADDR;
        else if (opClass.rtype)
          state_d = ST_R_EXEC;
        else if (opClass.cbz)
          state_d = ST_BRANCH;
        else if (opClass.b)
          state_d = ST_JUMP;
        else begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_DIMM;
        if (opClass.ldur)
          state_d = ST_MEM_RD;
        else if (opClass.stur)
          state_d = ST_MEM_WR;
        else
          state_d = ST_FETCH;
      end

      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          state_d = ST_LD_WB;
      end

      ST_LD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUop   = ALUOP_RTYPE;
        state_d = ST_R_WB;
      end

      ST_R_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_BRANCH: begin
        Reg2Loc     = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUop       = ALUOP_PASS;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end

      default: state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors go
// through a scoreboard queue, and instruction latencies through a second one.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUop;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        IorD, MemRead, MemWrite, IRWrite, RegWrite, PCWrite;
  logic        PCWriteCond, MemtoReg, Reg2Loc, PCSource, retire, illegal;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .MemtoReg    (MemtoReg),
    .Reg2Loc     (Reg2Loc),
    .PCSource    (PCSource),
    .retire      (retire),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Bit order: ALUop[16:15] SrcA[14] SrcB[13:12] IorD[11] MemRead[10]
  // MemWrite[9] IRWrite[8] RegWrite[7] PCWrite[6] PCWriteCond[5] MemtoReg[4]
  // Reg2Loc[3] PCSource[2] retire[1] illegal[0]
  logic [16:0] obs;
  assign obs = {ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                PCWrite, PCWriteCond, MemtoReg, Reg2Loc, PCSource, retire, illegal};

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100101;
  localparam logic [10:0] T_B    = 11'b00010111010;
  localparam logic [10:0] T_BAD0 = 11'b00000000000;
  localparam logic [10:0] T_BAD1 = 11'b11111000001;
  localparam logic [16:0] E_ZERO = 17'd0;

  logic [16:0] expQ[$];
  string       tagQ[$];
  int          latQ[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [10:0] curOp;
  logic        curZero;

  function automatic logic [16:0] eFetch(input logic mr);
    logic [16:0] v = '0;
    v[10] = 1'b1; v[13:12] = 2'b01; v[8] = mr; v[6] = mr;
    return v;
  endfunction

  function automatic logic [16:0] eDecode(input logic r2l, input logic ill);
    logic [16:0] v = '0;
    v[13:12] = 2'b11; v[3] = r2l; v[0] = ill;
    return v;
  endfunction

  function automatic logic [16:0] eMemAddr();
    logic [16:0] v = '0;
    v[14] = 1'b1; v[13:12] = 2'b10;
    return v;
  endfunction

  function automatic logic [16:0] eMemRd();
    logic [16:0] v = '0;
    v[11] = 1'b1; v[10] = 1'b1;
    return v;
  endfunction

  function automatic logic [16:0] eLdWb();
    logic [16:0] v = '0;
    v[7] = 1'b1; v[4] = 1'b1; v[1] = 1'b1;
    return v;
  endfunction

  function automatic logic [16:0] eMemWr(input logic mr);
    logic [16:0] v = '0;
    v[11] = 1'b1; v[9] = 1'b1; v[3] = 1'b1; v[1] = mr;
    return v;
  endfunction

  function automatic logic [16:0] eRExec();
    logic [16:0] v = '0;
    v[16:15] = 2'b10; v[14] = 1'b1;
    return v;
  endfunction

  function automatic logic [16:0] eRWb();
    logic [16:0] v = '0;
    v[7] = 1'b1; v[1] = 1'b1;
    return v;
  endfunction

  function automatic logic [16:0] eBranch();
    logic [16:0] v = '0;
    v[16:15] = 2'b01; v[14] = 1'b1; v[5] = 1'b1; v[3] = 1'b1; v[2] = 1'b1; v[1] = 1'b1;
    return v;
  endfunction

  function automatic logic [16:0] eJump();
    logic [16:0] v = '0;
    v[6] = 1'b1; v[2] = 1'b1; v[1] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput();
    logic [16:0] e;
    string       t;
    int          l;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    cyc++;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("[TB] FAIL %s obs=%h exp=%h", t, obs, e);
    end
    if (obs[1] | obs[0]) begin
      checks++;
      if (latQ.size() == 0) begin
        errors++;
        $error("[TB] FAIL %s_latency unexpected completion pulse at cycle %0d", t, cyc);
      end else begin
        l = latQ.pop_front();
        assert (cyc === l) else begin
          errors++;
          $error("[TB] FAIL %s_latency cycles=%0d exp=%0d", t, cyc, l);
        end
      end
    end
  endtask

  task automatic checkNow(input string tag, input logic [16:0] e);
    expQ.push_back(e);
    tagQ.push_back(tag);
    checkOutput();
  endtask

  task automatic applyStimulus(input string tag, input logic mr, input logic [16:0] e);
    @(posedge clk);
    #1;
    opcode    = curOp;
    zero      = curZero;
    mem_ready = mr;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic newInstr(input logic [10:0] op, input logic z, input int lat);
    curOp   = op;
    curZero = z;
    cyc     = 0;
    if (lat > 0) latQ.push_back(lat);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = T_ADD;
    zero      = 1'b0;
    mem_ready = 1'b1;
    curOp     = T_ADD;
    curZero   = 1'b0;
    #2;
    checkNow("reset_hold", E_ZERO);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkNow("reset_cycle", E_ZERO);

    newInstr(T_ADD, 1'b0, 4);
    applyStimulus("add_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("add_decode", 1'b0, eDecode(1'b0, 1'b0));
    applyStimulus("add_exec",   1'b0, eRExec());
    applyStimulus("add_wb",     1'b0, eRWb());

    newInstr(T_LDUR, 1'b0, 8);
    applyStimulus("ld_fetch_w1", 1'b0, eFetch(1'b0));
    applyStimulus("ld_fetch_w2", 1'b0, eFetch(1'b0));
    applyStimulus("ld_fetch",    1'b1, eFetch(1'b1));
    applyStimulus("ld_decode",   1'b0, eDecode(1'b0, 1'b0));
    applyStimulus("ld_addr",     1'b0, eMemAddr());
    applyStimulus("ld_rd_w1",    1'b0, eMemRd());
    applyStimulus("ld_rd",       1'b1, eMemRd());
    applyStimulus("ld_wb",       1'b0, eLdWb());

    newInstr(T_STUR, 1'b0, 6);
    applyStimulus("st_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("st_decode", 1'b1, eDecode(1'b1, 1'b0));
    applyStimulus("st_addr",   1'b1, eMemAddr());
    applyStimulus("st_wr_w1",  1'b0, eMemWr(1'b0));
    applyStimulus("st_wr_w2",  1'b0, eMemWr(1'b0));
    applyStimulus("st_wr",     1'b1, eMemWr(1'b1));

    newInstr(T_CBZ, 1'b1, 3);
    applyStimulus("cbz1_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("cbz1_decode", 1'b0, eDecode(1'b1, 1'b0));
    applyStimulus("cbz1_branch", 1'b0, eBranch());

    newInstr(T_CBZ, 1'b0, 3);
    applyStimulus("cbz0_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("cbz0_decode", 1'b1, eDecode(1'b1, 1'b0));
    applyStimulus("cbz0_branch", 1'b1, eBranch());

    newInstr(T_B, 1'b0, 3);
    applyStimulus("b_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("b_decode", 1'b0, eDecode(1'b0, 1'b0));
    applyStimulus("b_jump",   1'b0, eJump());

    newInstr(T_ORR, 1'b0, 4);
    applyStimulus("orr_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("orr_decode", 1'b1, eDecode(1'b0, 1'b0));
    applyStimulus("orr_exec",   1'b1, eRExec());
    applyStimulus("orr_wb",     1'b1, eRWb());

    newInstr(T_BAD0, 1'b0, 2);
    applyStimulus("ill0_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("ill0_decode", 1'b1, eDecode(1'b0, 1'b1));

    newInstr(T_BAD1, 1'b0, 2);
    applyStimulus("ill1_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("ill1_decode", 1'b0, eDecode(1'b0, 1'b1));

    newInstr(T_STUR, 1'b0, 4);
    applyStimulus("st2_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("st2_decode", 1'b0, eDecode(1'b1, 1'b0));
    applyStimulus("st2_addr",   1'b0, eMemAddr());
    applyStimulus("st2_wr",     1'b1, eMemWr(1'b1));

    // Store aborted by reset while waiting on memory: no latency is queued,
    // so any retire pulse from it is reported as unexpected.
    newInstr(T_STUR, 1'b0, 0);
    applyStimulus("abort_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("abort_decode", 1'b0, eDecode(1'b1, 1'b0));
    applyStimulus("abort_addr",   1'b0, eMemAddr());
    applyStimulus("abort_wr_w1",  1'b0, eMemWr(1'b0));
    @(posedge clk);
    #1 mem_ready = 1'b0;
    checkNow("abort_wr_w2", eMemWr(1'b0));
    #1 rst_n = 1'b0;
    #1 checkNow("abort_rst_drop", E_ZERO);
    mem_ready = 1'b1;
    #1 checkNow("abort_rst_ready", E_ZERO);
    @(negedge clk);
    checkNow("abort_rst_hold", E_ZERO);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkNow("abort_reset_cycle", E_ZERO);

    newInstr(T_ADD, 1'b0, 4);
    applyStimulus("add2_fetch",  1'b1, eFetch(1'b1));
    applyStimulus("add2_decode", 1'b1, eDecode(1'b0, 1'b0));
    applyStimulus("add2_exec",   1'b1, eRExec());
    applyStimulus("add2_wb",     1'b1, eRWb());

    checks++;
    assert (latQ.size() === 0) else begin
      errors++;
      $error("[TB] FAIL missing_completions pending=%0d exp=0", latQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
